// File: rtl/core_pkg.sv
// Shared definitions for the write-back / machine-trap stage.
// Holds the machine CSR addresses, the mstatus/mie/mip bit positions,
// the interrupt cause codes and the trap FSM state encoding.
package core_pkg;

   localparam logic [11:0] CSR_MSTATUS  = 12'h300;
   localparam logic [11:0] CSR_MIE      = 12'h304;
   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH = 12'h340;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;
   localparam logic [11:0] CSR_MTVAL    = 12'h343;
   localparam logic [11:0] CSR_MIP      = 12'h344;

   localparam int unsigned IRQ_CAUSE_MSI = 3;
   localparam int unsigned IRQ_CAUSE_MTI = 7;
   localparam int unsigned IRQ_CAUSE_MEI = 11;

   // mie/mip bit positions equal the interrupt cause codes
   localparam int unsigned MIX_MSI_BIT = IRQ_CAUSE_MSI;
   localparam int unsigned MIX_MTI_BIT = IRQ_CAUSE_MTI;
   localparam int unsigned MIX_MEI_BIT = IRQ_CAUSE_MEI;

   localparam int unsigned MSTATUS_MIE_BIT  = 3;
   localparam int unsigned MSTATUS_MPIE_BIT = 7;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SAVE   = 2'd1,
      TRAP_R = 2'd2,
      MRET_R = 2'd3
   } trap_state_e;

endpackage

// File: rtl/wb_trap_csr.sv
// Machine trap CSR storage for the write-back stage.
// Ports:
//   clk, rst_b                 clock, synchronous active-high reset
//   csr_addr/info/write/set/clear/commit   Zicsr access; commit gates the update
//   csr_rdata                  current (old) value of the addressed CSR, 0 if unimplemented
//   ext_irq/sw_irq/tmr_irq     interrupt levels, registered into mip
//   save_en/epc/cause/tval     trap entry update (also MPIE<=MIE, MIE<=0)
//   mret_en                    MRET update (MIE<=MPIE, MPIE<=1)
//   mstatus_mie, mie_bits, mip_bits, mtvec, mepc   state seen by the trap FSM
module wb_trap_csr
   import core_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
   input  logic            clk,
   input  logic            rst_b,
   input  logic [11:0]     csr_addr,
   input  logic [XLEN-1:0] csr_info,
   input  logic            csr_write,
   input  logic            csr_set,
   input  logic            csr_clear,
   input  logic            csr_commit,
   output logic [XLEN-1:0] csr_rdata,
   input  logic            ext_irq,
   input  logic            sw_irq,
   input  logic            tmr_irq,
   input  logic            save_en,
   input  logic [XLEN-1:0] save_epc,
   input  logic [XLEN-1:0] save_cause,
   input  logic [XLEN-1:0] save_tval,
   input  logic            mret_en,
   output logic            mstatus_mie,
   output logic [XLEN-1:0] mie_bits,
   output logic [XLEN-1:0] mip_bits,
   output logic [XLEN-1:0] mtvec,
   output logic [XLEN-1:0] mepc
);

   logic            mstatus_mpie;
   logic            mie_msie, mie_mtie, mie_meie;
   logic            mip_msip, mip_mtip, mip_meip;
   logic [XLEN-1:0] mscratch, mcause, mtval;
   logic [XLEN-1:0] mstatus_view, csr_wval;
   logic            csr_we;

   always_comb begin
      mstatus_view = '0;
      mstatus_view[MSTATUS_MIE_BIT]  = mstatus_mie;
      mstatus_view[MSTATUS_MPIE_BIT] = mstatus_mpie;
      mie_bits = '0;
      mie_bits[MIX_MSI_BIT] = mie_msie;
      mie_bits[MIX_MTI_BIT] = mie_mtie;
      mie_bits[MIX_MEI_BIT] = mie_meie;
      mip_bits = '0;
      mip_bits[MIX_MSI_BIT] = mip_msip;
      mip_bits[MIX_MTI_BIT] = mip_mtip;
      mip_bits[MIX_MEI_BIT] = mip_meip;
   end

   always_comb begin
      case (csr_addr)
         CSR_MSTATUS:  csr_rdata = mstatus_view;
         CSR_MIE:      csr_rdata = mie_bits;
         CSR_MTVEC:    csr_rdata = mtvec;
         CSR_MSCRATCH: csr_rdata = mscratch;
         CSR_MEPC:     csr_rdata = mepc;
         CSR_MCAUSE:   csr_rdata = mcause;
         CSR_MTVAL:    csr_rdata = mtval;
         CSR_MIP:      csr_rdata = mip_bits;
         default:      csr_rdata = '0;
      endcase
   end

   always_comb begin
      csr_wval = csr_rdata;
      if (csr_write)      csr_wval = csr_info;
      else if (csr_set)   csr_wval = csr_rdata | csr_info;
      else if (csr_clear) csr_wval = csr_rdata & ~csr_info;
   end

   assign csr_we = csr_commit & (csr_write | csr_set | csr_clear);

   always_ff @(posedge clk) begin
      if (rst_b) begin
         mstatus_mie  <= 1'b0;
         mstatus_mpie <= 1'b0;
         mie_msie     <= 1'b0;
         mie_mtie     <= 1'b0;
         mie_meie     <= 1'b0;
         mip_msip     <= 1'b0;
         mip_mtip     <= 1'b0;
         mip_meip     <= 1'b0;
         mtvec        <= RESET_MTVEC;
         mscratch     <= '0;
         mepc         <= '0;
         mcause       <= '0;
         mtval        <= '0;
      end else begin
         mip_msip <= sw_irq;
         mip_mtip <= tmr_irq;
         mip_meip <= ext_irq;
         if (save_en) begin
            mepc         <= save_epc;
            mcause       <= save_cause;
            mtval        <= save_tval;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
         end else if (mret_en) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
         end else if (csr_we) begin
            case (csr_addr)
               CSR_MSTATUS: begin
                  mstatus_mie  <= csr_wval[MSTATUS_MIE_BIT];
                  mstatus_mpie <= csr_wval[MSTATUS_MPIE_BIT];
               end
               CSR_MIE: begin
                  mie_msie <= csr_wval[MIX_MSI_BIT];
                  mie_mtie <= csr_wval[MIX_MTI_BIT];
                  mie_meie <= csr_wval[MIX_MEI_BIT];
               end
               // mtvec bit 1 is reserved and always reads 0
               CSR_MTVEC:    mtvec    <= {csr_wval[XLEN-1:2], 1'b0, csr_wval[0]};
               CSR_MSCRATCH: mscratch <= csr_wval;
               CSR_MEPC:     mepc     <= csr_wval;
               CSR_MCAUSE:   mcause   <= csr_wval;
               CSR_MTVAL:    mtval    <= csr_wval;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: rtl/wb_trap_stage.sv
// Write-back stage with machine-mode trap handling.
// Retires entries from the MEM->WB pipe to the register file, executes Zicsr
// accesses, and sequences exceptions, interrupts and MRET into a one-cycle
// flush plus PC redirect towards fetch.
// Ports:
//   clk, rst_b                      clock, synchronous active-high reset
//   wb_pipe_*                       incoming pipe entry and handshake (ready/flush out)
//   wb_rd_write/addr/wdata          register file write port
//   wb_retire                       instruction retired pulse
//   trap_redirect, trap_target      PC redirect strobe and target
//   external/software/timer_interrupt   interrupt levels
//
// state  | meaning
// IDLE   | retire entries; detect exception / interrupt / MRET
// SAVE   | write mepc/mcause/mtval, MPIE<=MIE, MIE<=0
// TRAP_R | flush + redirect to trap vector, drop the trapping entry
// MRET_R | flush + redirect to mepc, retire MRET, MIE<=MPIE
module wb_trap_stage
   import core_pkg::*;
#(
   parameter int              XLEN           = 32,
   parameter int              REG_AW         = 5,
   parameter int              CAUSE_W        = 4,
   parameter int              MTVEC_VECTORED = 1,
   parameter logic [XLEN-1:0] RESET_MTVEC    = '0
) (
   input  logic              clk,
   input  logic              rst_b,
   output logic              wb_pipe_ready,
   output logic              wb_pipe_flush,
   input  logic              wb_pipe_valid,
   input  logic [XLEN-1:0]   wb_pipe_pc,
   input  logic              wb_pipe_rd_write,
   input  logic [REG_AW-1:0] wb_pipe_rd_addr,
   input  logic [XLEN-1:0]   wb_pipe_rd_data,
   input  logic              wb_pipe_csr_write,
   input  logic              wb_pipe_csr_set,
   input  logic              wb_pipe_csr_clear,
   input  logic              wb_pipe_csr_read,
   input  logic [XLEN-1:0]   wb_pipe_csr_info,
   input  logic [11:0]       wb_pipe_csr_addr,
   input  logic              wb_pipe_exc_pending,
   input  logic [CAUSE_W-1:0] wb_pipe_exc_code,
   input  logic [XLEN-1:0]   wb_pipe_exc_tval,
   input  logic              wb_pipe_mret,
   output logic              wb_rd_write,
   output logic [REG_AW-1:0] wb_rd_addr,
   output logic [XLEN-1:0]   wb_rd_wdata,
   output logic              wb_retire,
   output logic              trap_redirect,
   output logic [XLEN-1:0]   trap_target,
   input  logic              external_interrupt,
   input  logic              software_interrupt,
   input  logic              timer_interrupt
);

   trap_state_e        state_q, state_d;
   logic [CAUSE_W-1:0] code_q, irq_code;
   logic               is_irq_q;
   logic [XLEN-1:0]    tval_q;
   logic [XLEN-1:0]    mie_bits, mip_bits, mtvec, mepc, csr_rdata, irq_pend;
   logic [XLEN-1:0]    trap_base, trap_vec, save_cause;
   logic               mstatus_mie, irq, take_trap;
   logic               csr_commit, save_en, mret_en;

   assign irq_pend  = mip_bits & mie_bits;
   assign irq       = mstatus_mie & (|irq_pend);
   assign take_trap = wb_pipe_valid & (wb_pipe_exc_pending | irq);

   // Only consulted when irq is set; if neither MEI nor MSI is pending, MTI is.
   always_comb begin
      irq_code = CAUSE_W'(IRQ_CAUSE_MTI);
      if (irq_pend[MIX_MEI_BIT])      irq_code = CAUSE_W'(IRQ_CAUSE_MEI);
      else if (irq_pend[MIX_MSI_BIT]) irq_code = CAUSE_W'(IRQ_CAUSE_MSI);
   end

   always_ff @(posedge clk) begin
      if (rst_b) begin
         state_q  <= IDLE;
         code_q   <= '0;
         is_irq_q <= 1'b0;
         tval_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && take_trap) begin
            is_irq_q <= ~wb_pipe_exc_pending;
            code_q   <= wb_pipe_exc_pending ? wb_pipe_exc_code : irq_code;
            tval_q   <= wb_pipe_exc_pending ? wb_pipe_exc_tval : '0;
         end
      end
   end

   assign save_cause = {is_irq_q, {(XLEN-1-CAUSE_W){1'b0}}, code_q};
   assign trap_base  = mtvec & ~XLEN'(3);
   assign trap_vec   = ((MTVEC_VECTORED != 0) && mtvec[0] && is_irq_q)
                       ? trap_base + (XLEN'(code_q) << 2) : trap_base;

   always_comb begin
      state_d       = state_q;
      wb_pipe_ready = 1'b0;
      wb_pipe_flush = 1'b0;
      wb_rd_write   = 1'b0;
      wb_rd_addr    = '0;
      wb_rd_wdata   = '0;
      wb_retire     = 1'b0;
      trap_redirect = 1'b0;
      trap_target   = '0;
      csr_commit    = 1'b0;
      save_en       = 1'b0;
      mret_en       = 1'b0;
      case (state_q)
         IDLE: begin
            wb_pipe_ready = 1'b1;
            if (wb_pipe_valid) begin
               if (take_trap) begin
                  wb_pipe_ready = 1'b0;
                  state_d       = SAVE;
               end else if (wb_pipe_mret) begin
                  wb_pipe_ready = 1'b0;
                  state_d       = MRET_R;
               end else begin
                  wb_retire   = 1'b1;
                  wb_rd_write = wb_pipe_rd_write;
                  wb_rd_addr  = wb_pipe_rd_addr;
                  wb_rd_wdata = wb_pipe_csr_read ? csr_rdata : wb_pipe_rd_data;
                  csr_commit  = 1'b1;
               end
            end
         end
         SAVE: begin
            save_en = 1'b1;
            state_d = TRAP_R;
         end
         TRAP_R: begin
            wb_pipe_ready = 1'b1;
            wb_pipe_flush = 1'b1;
            trap_redirect = 1'b1;
            trap_target   = trap_vec;
            state_d       = IDLE;
         end
         MRET_R: begin
            wb_pipe_ready = 1'b1;
            wb_pipe_flush = 1'b1;
            trap_redirect = 1'b1;
            wb_retire     = 1'b1;
            trap_target   = mepc;
            mret_en       = 1'b1;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // While reset is held, present the idle interface and suppress any redirect.
      if (rst_b) begin
         state_d       = IDLE;
         wb_pipe_ready = 1'b1;
         wb_pipe_flush = 1'b0;
         wb_rd_write   = 1'b0;
         wb_rd_addr    = '0;
         wb_rd_wdata   = '0;
         wb_retire     = 1'b0;
         trap_redirect = 1'b0;
         trap_target   = '0;
         csr_commit    = 1'b0;
         save_en       = 1'b0;
         mret_en       = 1'b0;
      end
   end

   wb_trap_csr #(
      .XLEN        (XLEN),
      .RESET_MTVEC (RESET_MTVEC)
   ) u_csr (
      .clk         (clk),
      .rst_b       (rst_b),
      .csr_addr    (wb_pipe_csr_addr),
      .csr_info    (wb_pipe_csr_info),
      .csr_write   (wb_pipe_csr_write),
      .csr_set     (wb_pipe_csr_set),
      .csr_clear   (wb_pipe_csr_clear),
      .csr_commit  (csr_commit),
      .csr_rdata   (csr_rdata),
      .ext_irq     (external_interrupt),
      .sw_irq      (software_interrupt),
      .tmr_irq     (timer_interrupt),
      .save_en     (save_en),
      .save_epc    (wb_pipe_pc & ~XLEN'(3)),
      .save_cause  (save_cause),
      .save_tval   (tval_q),
      .mret_en     (mret_en),
      .mstatus_mie (mstatus_mie),
      .mie_bits    (mie_bits),
      .mip_bits    (mip_bits),
      .mtvec       (mtvec),
      .mepc        (mepc)
   );

endmodule

// File: tb/tb_wb_trap_stage.sv
module tb_wb_trap_stage;

   logic        clk = 1'b0;
   logic        rst_b = 1'b1;
   logic        wb_pipe_ready, wb_pipe_flush;
   logic        wb_pipe_valid = 1'b0;
   logic [31:0] wb_pipe_pc = '0;
   logic        wb_pipe_rd_write = 1'b0;
   logic [4:0]  wb_pipe_rd_addr = '0;
   logic [31:0] wb_pipe_rd_data = '0;
   logic        wb_pipe_csr_write = 1'b0, wb_pipe_csr_set = 1'b0;
   logic        wb_pipe_csr_clear = 1'b0, wb_pipe_csr_read = 1'b0;
   logic [31:0] wb_pipe_csr_info = '0;
   logic [11:0] wb_pipe_csr_addr = '0;
   logic        wb_pipe_exc_pending = 1'b0;
   logic [3:0]  wb_pipe_exc_code = '0;
   logic [31:0] wb_pipe_exc_tval = '0;
   logic        wb_pipe_mret = 1'b0;
   logic        wb_rd_write;
   logic [4:0]  wb_rd_addr;
   logic [31:0] wb_rd_wdata;
   logic        wb_retire, trap_redirect;
   logic [31:0] trap_target;
   logic        external_interrupt = 1'b0, software_interrupt = 1'b0, timer_interrupt = 1'b0;

   int passed = 0;
   int total  = 0;

   // One observed/expected acceptance of a pipe entry.
   typedef struct packed {
      logic [3:0]  stall;   // cycles with ready low before acceptance (F = timeout)
      logic        early;   // any write/retire/redirect seen while stalled
      logic        redir;
      logic        flush;
      logic        retire;
      logic        rd_wr;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [31:0] target;
   } rec_t;

   rec_t exp_q[$];
   rec_t obs;

   wb_trap_stage dut (
      .clk                 (clk),
      .rst_b               (rst_b),
      .wb_pipe_ready       (wb_pipe_ready),
      .wb_pipe_flush       (wb_pipe_flush),
      .wb_pipe_valid       (wb_pipe_valid),
      .wb_pipe_pc          (wb_pipe_pc),
      .wb_pipe_rd_write    (wb_pipe_rd_write),
      .wb_pipe_rd_addr     (wb_pipe_rd_addr),
      .wb_pipe_rd_data     (wb_pipe_rd_data),
      .wb_pipe_csr_write   (wb_pipe_csr_write),
      .wb_pipe_csr_set     (wb_pipe_csr_set),
      .wb_pipe_csr_clear   (wb_pipe_csr_clear),
      .wb_pipe_csr_read    (wb_pipe_csr_read),
      .wb_pipe_csr_info    (wb_pipe_csr_info),
      .wb_pipe_csr_addr    (wb_pipe_csr_addr),
      .wb_pipe_exc_pending (wb_pipe_exc_pending),
      .wb_pipe_exc_code    (wb_pipe_exc_code),
      .wb_pipe_exc_tval    (wb_pipe_exc_tval),
      .wb_pipe_mret        (wb_pipe_mret),
      .wb_rd_write         (wb_rd_write),
      .wb_rd_addr          (wb_rd_addr),
      .wb_rd_wdata         (wb_rd_wdata),
      .wb_retire           (wb_retire),
      .trap_redirect       (trap_redirect),
      .trap_target         (trap_target),
      .external_interrupt  (external_interrupt),
      .software_interrupt  (software_interrupt),
      .timer_interrupt     (timer_interrupt)
   );

   always #5 clk = ~clk;

   function automatic rec_t mk_rec(input int stall, input logic redir, flush, retire, rd_wr,
                                   input logic [4:0] addr, input logic [31:0] wdata, target);
      rec_t r;
      r.stall  = 4'(stall);
      r.early  = 1'b0;
      r.redir  = redir;
      r.flush  = flush;
      r.retire = retire;
      r.rd_wr  = rd_wr;
      r.addr   = addr;
      r.wdata  = wdata;
      r.target = target;
      return r;
   endfunction

   task automatic clr_pipe();
      wb_pipe_valid = 1'b0;       wb_pipe_pc = '0;
      wb_pipe_rd_write = 1'b0;    wb_pipe_rd_addr = '0;   wb_pipe_rd_data = '0;
      wb_pipe_csr_write = 1'b0;   wb_pipe_csr_set = 1'b0;
      wb_pipe_csr_clear = 1'b0;   wb_pipe_csr_read = 1'b0;
      wb_pipe_csr_info = '0;      wb_pipe_csr_addr = '0;
      wb_pipe_exc_pending = 1'b0; wb_pipe_exc_code = '0;  wb_pipe_exc_tval = '0;
      wb_pipe_mret = 1'b0;
   endtask

   // Present the entry already set up on wb_pipe_* and hold it until accepted.
   // Called and returns at posedge+1.
   task automatic fire();
      int  n = 0;
      bit  done = 1'b0;
      obs = '0;
      wb_pipe_valid = 1'b1;
      while (!done && n < 8) begin
         @(negedge clk);
         if (wb_pipe_ready) done = 1'b1;
         else begin
            obs.early = obs.early | wb_rd_write | wb_retire | trap_redirect;
            n++;
         end
      end
      if (!done) obs.stall = 4'hF;
      else begin
         obs.stall  = 4'(n);
         obs.redir  = trap_redirect;
         obs.flush  = wb_pipe_flush;
         obs.retire = wb_retire;
         obs.rd_wr  = wb_rd_write;
         obs.addr   = wb_rd_addr;
         obs.wdata  = wb_rd_wdata;
         obs.target = trap_target;
      end
      @(posedge clk); #1;
      clr_pipe();
   endtask

   // CSR instruction writing its old value to x1.
   task automatic drive_csr(input logic w, s, c, input logic [11:0] a, input logic [31:0] info);
      wb_pipe_pc = 32'h1000;
      wb_pipe_csr_write = w; wb_pipe_csr_set = s; wb_pipe_csr_clear = c;
      wb_pipe_csr_read = 1'b1; wb_pipe_csr_addr = a; wb_pipe_csr_info = info;
      wb_pipe_rd_write = 1'b1; wb_pipe_rd_addr = 5'd1;
      fire();
   endtask

   task automatic test_reset();
      rec_t e;
      logic [11:0] ra [3] = '{12'h305, 12'h300, 12'h341};
      wb_pipe_valid = 1'b1; wb_pipe_rd_write = 1'b1; wb_pipe_rd_addr = 5'd5; wb_pipe_rd_data = 32'h1;
      @(negedge clk); @(negedge clk);
      total++;
      if ({wb_pipe_ready, wb_retire, wb_rd_write, trap_redirect} !== 4'b1000)
         $display("FAIL reset_held: ready/retire/rd_write/redirect got %b expected 1000",
                  {wb_pipe_ready, wb_retire, wb_rd_write, trap_redirect});
      else passed++;
      clr_pipe();
      @(posedge clk); #1; rst_b = 1'b0;
      @(negedge clk);
      total++;
      if ({wb_pipe_ready, wb_pipe_flush, wb_rd_write, wb_rd_addr, wb_rd_wdata, wb_retire,
           trap_redirect, trap_target} !== {1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0})
         $display("FAIL reset_idle: outputs got %h", {wb_pipe_ready, wb_pipe_flush, wb_rd_write,
                  wb_rd_addr, wb_rd_wdata, wb_retire, trap_redirect, trap_target});
      else passed++;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(mk_rec(0, 0, 0, 1, 1, 5'd1, 32'h0, 32'h0));
         drive_csr(1'b0, 1'b1, 1'b0, ra[i], 32'h0);
         e = exp_q.pop_front(); total++;
         if (obs !== e) $display("FAIL reset_csr_%h: got %p expected %p", ra[i], obs, e);
         else passed++;
      end
   endtask

   task automatic test_retire();
      rec_t e;
      logic        rw [3] = '{1'b1, 1'b1, 1'b0};
      logic [4:0]  ra [3] = '{5'd5, 5'd0, 5'd7};
      logic [31:0] rd [3] = '{32'h1234, 32'h55, 32'h99};
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(mk_rec(0, 0, 0, 1, rw[i], ra[i], rd[i], 32'h0));
         wb_pipe_pc = 32'h10 + 32'(i * 4);
         wb_pipe_rd_write = rw[i]; wb_pipe_rd_addr = ra[i]; wb_pipe_rd_data = rd[i];
         fire();
         e = exp_q.pop_front(); total++;
         if (obs !== e) $display("FAIL retire_%0d: got %p expected %p", i, obs, e);
         else passed++;
      end
   endtask

   task automatic test_csr_rw();
      rec_t e;
      logic [2:0]  op  [4] = '{3'b100, 3'b010, 3'b001, 3'b010};
      logic [31:0] inf [4] = '{32'hA5A5_0000, 32'h0000_00FF, 32'hA500_0000, 32'h0};
      logic [31:0] old [4] = '{32'h11, 32'hA5A5_0000, 32'hA5A5_00FF, 32'h00A5_00FF};
      drive_csr(1'b1, 1'b0, 1'b0, 12'h340, 32'h11);
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(mk_rec(0, 0, 0, 1, 1, 5'd1, old[i], 32'h0));
         drive_csr(op[i][2], op[i][1], op[i][0], 12'h340, inf[i]);
         e = exp_q.pop_front(); total++;
         if (obs !== e) $display("FAIL mscratch_%0d: got %p expected %p", i, obs, e);
         else passed++;
      end
   endtask

   task automatic test_exception();
      rec_t e;
      logic [11:0] ra [4] = '{12'h341, 12'h342, 12'h343, 12'h300};
      logic [31:0] rv [4] = '{32'h80, 32'h2, 32'hDEAD, 32'h80};
      drive_csr(1'b1, 1'b0, 1'b0, 12'h305, 32'h100);
      drive_csr(1'b1, 1'b0, 1'b0, 12'h300, 32'h8);
      exp_q.push_back(mk_rec(2, 1, 1, 0, 0, 5'd0, 32'h0, 32'h100));
      wb_pipe_pc = 32'h80; wb_pipe_exc_pending = 1'b1; wb_pipe_exc_code = 4'd2;
      wb_pipe_exc_tval = 32'hDEAD;
      wb_pipe_rd_write = 1'b1; wb_pipe_rd_addr = 5'd3; wb_pipe_rd_data = 32'h77;
      fire();
      e = exp_q.pop_front(); total++;
      if (obs !== e) $display("FAIL illegal_trap: got %p expected %p", obs, e);
      else passed++;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(mk_rec(0, 0, 0, 1, 1, 5'd1, rv[i], 32'h0));
         drive_csr(1'b0, 1'b1, 1'b0, ra[i], 32'h0);
         e = exp_q.pop_front(); total++;
         if (obs !== e) $display("FAIL illegal_csr_%h: got %p expected %p", ra[i], obs, e);
         else passed++;
      end
   endtask

   task automatic test_timer_irq();
      rec_t e;
      logic [11:0] ra [5] = '{12'h342, 12'h341, 12'h343, 12'h300, 12'h344};
      logic [31:0] rv [5] = '{32'h8000_0007, 32'h40, 32'h0, 32'h80, 32'h80};
      drive_csr(1'b1, 1'b0, 1'b0, 12'h305, 32'h201);
      drive_csr(1'b1, 1'b0, 1'b0, 12'h304, 32'h80);
      timer_interrupt = 1'b1;
      @(posedge clk); #1;
      drive_csr(1'b1, 1'b0, 1'b0, 12'h300, 32'h8);
      exp_q.push_back(mk_rec(2, 1, 1, 0, 0, 5'd0, 32'h0, 32'h21C));
      wb_pipe_pc = 32'h40; wb_pipe_rd_write = 1'b1; wb_pipe_rd_addr = 5'd4; wb_pipe_rd_data = 32'h3;
      fire();
      e = exp_q.pop_front(); total++;
      if (obs !== e) $display("FAIL timer_trap: got %p expected %p", obs, e);
      else passed++;
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(mk_rec(0, 0, 0, 1, 1, 5'd1, rv[i], 32'h0));
         drive_csr(1'b0, 1'b1, 1'b0, ra[i], 32'h0);
         e = exp_q.pop_front(); total++;
         if (obs !== e) $display("FAIL timer_csr_%h: got %p expected %p", ra[i], obs, e);
         else passed++;
      end
      timer_interrupt = 1'b0;
   endtask

   task automatic test_mret();
      rec_t e;
      drive_csr(1'b1, 1'b0, 1'b0, 12'h341, 32'h44);
      exp_q.push_back(mk_rec(1, 1, 1, 1, 0, 5'd0, 32'h0, 32'h44));
      wb_pipe_pc = 32'h50; wb_pipe_mret = 1'b1;
      fire();
      e = exp_q.pop_front(); total++;
      if (obs !== e) $display("FAIL mret: got %p expected %p", obs, e);
      else passed++;
      exp_q.push_back(mk_rec(0, 0, 0, 1, 1, 5'd1, 32'h88, 32'h0));
      drive_csr(1'b0, 1'b1, 1'b0, 12'h300, 32'h0);
      e = exp_q.pop_front(); total++;
      if (obs !== e) $display("FAIL mret_mstatus: got %p expected %p", obs, e);
      else passed++;
   endtask

   task automatic test_exc_vs_irq();
      rec_t e;
      drive_csr(1'b1, 1'b0, 1'b0, 12'h304, 32'h880);
      external_interrupt = 1'b1;
      @(posedge clk); #1;
      exp_q.push_back(mk_rec(2, 1, 1, 0, 0, 5'd0, 32'h0, 32'h200));
      wb_pipe_pc = 32'h62; wb_pipe_exc_pending = 1'b1; wb_pipe_exc_code = 4'd5;
      wb_pipe_exc_tval = 32'h5;
      fire();
      e = exp_q.pop_front(); total++;
      if (obs !== e) $display("FAIL exc_vs_irq_trap: got %p expected %p", obs, e);
      else passed++;
      external_interrupt = 1'b0;
      exp_q.push_back(mk_rec(0, 0, 0, 1, 1, 5'd1, 32'h5, 32'h0));
      drive_csr(1'b0, 1'b1, 1'b0, 12'h342, 32'h0);
      e = exp_q.pop_front(); total++;
      if (obs !== e) $display("FAIL exc_vs_irq_mcause: got %p expected %p", obs, e);
      else passed++;
      exp_q.push_back(mk_rec(0, 0, 0, 1, 1, 5'd1, 32'h60, 32'h0));
      drive_csr(1'b0, 1'b1, 1'b0, 12'h341, 32'h0);
      e = exp_q.pop_front(); total++;
      if (obs !== e) $display("FAIL exc_vs_irq_mepc: got %p expected %p", obs, e);
      else passed++;
   endtask

   task automatic test_reset_mid_trap();
      rec_t e;
      logic redir_seen = 1'b0;
      logic [11:0] ra [4] = '{12'h341, 12'h342, 12'h305, 12'h300};
      wb_pipe_pc = 32'h90; wb_pipe_exc_pending = 1'b1; wb_pipe_exc_code = 4'd2;
      wb_pipe_exc_tval = 32'h1; wb_pipe_valid = 1'b1;
      @(posedge clk); #1;
      rst_b = 1'b1; clr_pipe();
      @(negedge clk); redir_seen = redir_seen | trap_redirect;
      @(posedge clk); #1; rst_b = 1'b0;
      repeat (3) begin
         @(negedge clk); redir_seen = redir_seen | trap_redirect;
      end
      total++;
      if ({redir_seen, wb_pipe_ready} !== 2'b01)
         $display("FAIL reset_mid_trap: redirect_seen/ready got %b expected 01",
                  {redir_seen, wb_pipe_ready});
      else passed++;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(mk_rec(0, 0, 0, 1, 1, 5'd1, 32'h0, 32'h0));
         drive_csr(1'b0, 1'b1, 1'b0, ra[i], 32'h0);
         e = exp_q.pop_front(); total++;
         if (obs !== e) $display("FAIL mid_reset_csr_%h: got %p expected %p", ra[i], obs, e);
         else passed++;
      end
   endtask

   task automatic test_csr_edge();
      rec_t e;
      logic [11:0] ra [4] = '{12'h7C0, 12'h344, 12'h305, 12'h344};
      logic [31:0] rv [4] = '{32'h0, 32'h0, 32'hFFFF_FFFD, 32'h8};
      for (int i = 0; i < 3; i++) drive_csr(1'b1, 1'b0, 1'b0, ra[i], 32'hFFFF_FFFF);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) begin
            software_interrupt = 1'b1;
            @(posedge clk); #1;
         end
         exp_q.push_back(mk_rec(0, 0, 0, 1, 1, 5'd1, rv[i], 32'h0));
         drive_csr(1'b0, 1'b1, 1'b0, ra[i], 32'h0);
         e = exp_q.pop_front(); total++;
         if (obs !== e) $display("FAIL csr_edge_%0d: got %p expected %p", i, obs, e);
         else passed++;
      end
      software_interrupt = 1'b0;
   endtask

   initial begin
      test_reset();
      test_retire();
      test_csr_rw();
      test_exception();
      test_timer_irq();
      test_mret();
      test_exc_vs_irq();
      test_reset_mid_trap();
      test_csr_edge();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
      $fatal(1);
   end

endmodule

// File: doc/wb_trap_stage.md
Name: wb_trap_stage

Overview:
- Parametrised successor of the write-back stage. Retires instructions to the register file and executes Zicsr accesses.
- Adds machine-mode trap handling: synchronous exceptions, MRET, and external/software/timer interrupts.
- Sequences traps through a small FSM that saves mepc/mcause/mtval, updates mstatus, and drives one-cycle flush plus PC redirect to the fetch stage.
- Sits at the tail of the MEM->WB pipeline. Owns the machine trap CSRs.

Parameters:
- XLEN, 32, datapath / CSR width
- REG_AW, 5, register address width
- CAUSE_W, 4, exception code width
- MTVEC_VECTORED, 1, 1 = honour mtvec.MODE==1 for interrupts; 0 = direct mode only
- RESET_MTVEC, 32'h0000_0000, mtvec reset value

Ports:
- clk  in  1  clock
- rst_b  in  1  reset (synchronous, active-high)
- wb_pipe_ready  out  1  WB accepts the current pipe entry this cycle
- wb_pipe_flush  out  1  flush all younger stages
- wb_pipe_valid  in  1  pipe entry valid
- wb_pipe_pc  in  XLEN  instruction PC
- wb_pipe_rd_write  in  1  rd write request
- wb_pipe_rd_addr  in  REG_AW  rd address
- wb_pipe_rd_data  in  XLEN  rd data
- wb_pipe_csr_write / _set / _clear / _read  in  1 each  CSR op
- wb_pipe_csr_info  in  XLEN  CSR operand
- wb_pipe_csr_addr  in  12  CSR address
- wb_pipe_exc_pending  in  1  synchronous exception
- wb_pipe_exc_code  in  CAUSE_W  exception cause
- wb_pipe_exc_tval  in  XLEN  exception tval
- wb_pipe_mret  in  1  MRET instruction
- wb_rd_write  out  1  register write enable
- wb_rd_addr  out  REG_AW  register address
- wb_rd_wdata  out  XLEN  register write data
- wb_retire  out  1  instruction retired pulse
- trap_redirect  out  1  PC redirect strobe
- trap_target  out  XLEN  redirect PC
- external_interrupt / software_interrupt / timer_interrupt  in  1 each  interrupt levels

Behaviour:
- Reset (rst_b=1 at a clk edge):
  - State = IDLE.
  - All outputs 0 except wb_pipe_ready=1 and wb_rd_addr=0.
  - mstatus.MIE = 0, mstatus.MPIE = 0, mie = 0, mip = 0, mepc = 0, mcause = 0, mtval = 0.
  - mtvec = RESET_MTVEC.
- Upstream holds all wb_pipe_* stable while valid=1 and ready=0.
- mip.MEIP/MSIP/MTIP are registered copies of the interrupt inputs (1-cycle sample latency). mip is read-only to software.
- Interrupt take condition: irq = mstatus.MIE & |(mip & mie).
- Priority: exception > MEI (cause 11) > MSI (3) > MTI (7). Interrupt cause is recorded with mcause[XLEN-1] = 1.
- IDLE:
  - valid & !exc & !irq & !mret: retire in the same cycle.
    - ready = 1, wb_retire = 1.
    - wb_rd_write = rd_write.
    - wdata = csr_read ? csr_old_value : rd_data.
    - CSR write/set/clear committed at clk.
  - valid & (exc | irq): ready = 0, no rd write, no CSR op. Latch cause and tval (tval = 0 for interrupts). Go to SAVE.
  - valid & mret & !exc & !irq: ready = 0. Go to MRET_R.
  - !valid: no action. Interrupts are not taken without a valid entry.
- SAVE (1 cycle):
  - ready = 0.
  - mepc <= pc with bits [1:0] cleared; mcause, mtval written.
  - MPIE <= MIE; MIE <= 0.
  - Go to TRAP_R.
- TRAP_R (1 cycle):
  - trap_redirect = 1, wb_pipe_flush = 1, ready = 1 (drops the trapping entry). wb_retire = 0.
  - trap_target = {mtvec[XLEN-1:2], 2'b00} + (MTVEC_VECTORED & mtvec[0] & interrupt ? 4*cause : 0).
  - Go to IDLE.
- MRET_R (1 cycle):
  - trap_redirect = 1, flush = 1, ready = 1, wb_retire = 1.
  - trap_target = mepc.
  - MIE <= MPIE; MPIE <= 1.
  - Go to IDLE.
- Exception-to-redirect latency: 3 cycles (IDLE, SAVE, TRAP_R). MRET latency: 2 cycles.
- Interrupt edges arriving in SAVE/TRAP_R/MRET_R are only evaluated on return to IDLE.
- CSR access to an unimplemented address: read returns 0, write ignored. Writes to mip, and to mtvec bit 1, are ignored.
- CSR write to mstatus/mie retiring in cycle N affects irq in cycle N+1.
- Reset asserted mid-trap: returns to IDLE with reset values. No redirect is issued.
- wb_rd_write is never asserted for rd_addr==0 when the register file ignores x0. The block itself passes rd_write unmodified.

Decomposition:
- Shared package core_pkg:
  - CSR address constants (MSTATUS=12'h300, MIE=12'h304, MTVEC=12'h305, MSCRATCH=12'h340, MEPC=12'h341, MCAUSE=12'h342, MTVAL=12'h343, MIP=12'h344).
  - Interrupt cause constants.
  - State enum {IDLE, SAVE, TRAP_R, MRET_R}.
- One sub-module, wb_trap_csr:
  - Machine CSR storage, read mux, and write/set/clear arithmetic.
  - Trap-save and MRET update ports.
- The FSM, interrupt arbitration and redirect logic live in wb_trap_stage.

Test Plan:
- Plain retire: valid, rd_write=1, rd_addr=5, rd_data=32'h1234 -> same cycle wb_rd_write=1, addr=5, wdata=32'h1234, wb_retire=1, ready=1.
- CSRRW mscratch: csr_info=32'hA5A5_0000, old value 32'h11 -> wdata=32'h11; next read returns 32'hA5A5_0000.
- Illegal-instruction exception: pc=32'h80, code=2, tval=32'hDEAD, mtvec=32'h100 -> ready low 2 cycles; mepc=32'h80, mcause=2, mtval=32'hDEAD, MIE=0; cycle 3 redirect=1, flush=1, target=32'h100; no rd write.
- Vectored timer interrupt: mtvec=32'h201, mie.MTIE=1, MIE=1, timer_interrupt=1, valid pc=32'h40 -> mcause=32'h8000_0007, mepc=32'h40, target=32'h21C; instruction not retired.
- MRET: mepc=32'h44, MPIE=1 -> after 2 cycles redirect to 32'h44, MIE=1, wb_retire=1.
- Simultaneous exception code 5 and pending external interrupt -> mcause=5, interrupt bit 0. Reset asserted during SAVE -> IDLE, no redirect, mepc=0.
